header_window_buffer: RTL

//  Front stage of each parser pipeline. Collects the first CANDI_NUM bytes of every packet

---
 rtl/parser_pkg.sv | 10 +
 rtl/hwb_beat_mask.sv | 20 ++
 rtl/header_window_buffer.sv | 104 ++++++++++
 3 files changed

// File: rtl/parser_pkg.sv
// parser_pkg: shared types and sizing constants for the parser front end
package parser_pkg;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, OUT} hwb_state_e;

    localparam int HDR_BYTES      = 128;
    localparam int BEAT_BYTES_DEF = 32;
    localparam int BEATS_PER_WIN  = HDR_BYTES / BEAT_BYTES_DEF;

endpackage

// File: rtl/hwb_beat_mask.sv
// hwb_beat_mask: zeroes the bytes of an eop beat that lie at or beyond its valid length
//   i_data/o_data : beat in / masked beat out, byte k = [8k+7:8k]
//   i_eop, i_len  : mask only applies on the eop beat, bytes k >= i_len become 0
module hwb_beat_mask #(
    parameter int BEAT_BYTES = 32,
    parameter int BLEN_W     = 6
) (
    input  logic [BEAT_BYTES*8-1:0] i_data,
    input  logic                    i_eop,
    input  logic [BLEN_W-1:0]       i_len,
    output logic [BEAT_BYTES*8-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        for (int k = 0; k < BEAT_BYTES; k++)
            o_data[k*8 +: 8] = (i_eop && i_len <= BLEN_W'(k)) ? 8'd0 : i_data[k*8 +: 8];
    end

endmodule

// File: rtl/header_window_buffer.sv
// header_window_buffer: captures the first CANDI_NUM bytes of each packet into a header window
//   ingress : i_data_valid/o_data_ready beat handshake with sop/eop/len framing
//   egress  : o_hdr_valid/i_hdr_ready window handshake with o_hdr_data and o_hdr_len
//   o_err_cnt counts dropped orphan beats and aborted (eop-less) packets, saturating
module header_window_buffer
    import parser_pkg::*;
#(
    parameter int CANDI_NUM    = HDR_BYTES,
    parameter int OFFSET_WIDTH = 7,
    parameter int BEAT_BYTES   = BEAT_BYTES_DEF,
    parameter int BLEN_W       = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_data_valid,
    input  logic [BEAT_BYTES*8-1:0]   i_data,
    input  logic                      i_data_sop,
    input  logic                      i_data_eop,
    input  logic [BLEN_W-1:0]         i_data_len,
    output logic                      o_data_ready,
    output logic                      o_hdr_valid,
    output logic [CANDI_NUM-1:0][7:0] o_hdr_data,
    output logic [OFFSET_WIDTH:0]     o_hdr_len,
    input  logic                      i_hdr_ready,
    output logic [15:0]               o_err_cnt
);

    localparam int BPW = CANDI_NUM / BEAT_BYTES;
    localparam int SW  = OFFSET_WIDTH + 2;

    hwb_state_e               state_q, state_d;
    logic [OFFSET_WIDTH:0]    ptr_q, ptr_d;
    logic [OFFSET_WIDTH:0]    len_q, len_d;
    logic [CANDI_NUM*8-1:0]   win_q, win_d;
    logic [15:0]              err_q, err_d;
    logic [BEAT_BYTES*8-1:0]  beat;
    logic [SW-1:0]            base, nxt, sum;

    hwb_beat_mask #(.BEAT_BYTES(BEAT_BYTES), .BLEN_W(BLEN_W)) u_mask (
        .i_data (i_data),
        .i_eop  (i_data_eop),
        .i_len  (i_data_len),
        .o_data (beat)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        win_d   = win_q;
        err_d   = err_q;
        // a sop beat always restarts at byte 0, aborting any open packet
        base    = i_data_sop ? '0 : SW'(ptr_q);
        nxt     = base + SW'(BEAT_BYTES);
        sum     = base + SW'(i_data_len);
        if (state_q == OUT) begin
            if (i_hdr_ready) begin
                state_d = IDLE;
                ptr_d   = '0;
                len_d   = '0;
                win_d   = '0;
            end
        end else if (i_data_valid) begin
            if (i_data_sop ? state_q != IDLE : state_q == IDLE)
                err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
            if (i_data_sop)
                win_d = '0;
            if (i_data_sop || state_q == FILL) begin
                for (int s = 0; s < BPW; s++)
                    if (base == SW'(s*BEAT_BYTES))
                        win_d[s*BEAT_BYTES*8 +: BEAT_BYTES*8] = beat;
                ptr_d   = nxt[OFFSET_WIDTH:0];
                state_d = i_data_eop ? OUT : (nxt >= SW'(CANDI_NUM) ? DRAIN : FILL);
                len_d   = i_data_eop ? (sum > SW'(CANDI_NUM) ? (OFFSET_WIDTH+1)'(CANDI_NUM) : sum[OFFSET_WIDTH:0])
                        : (nxt >= SW'(CANDI_NUM) ? (OFFSET_WIDTH+1)'(CANDI_NUM) : len_q);
            end else if (state_q == DRAIN && i_data_eop) begin
                state_d = OUT;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            len_q   <= '0;
            win_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            win_q   <= win_d;
            err_q   <= err_d;
        end
    end

    assign o_data_ready = (state_q != OUT);
    assign o_hdr_valid  = (state_q == OUT);
    assign o_hdr_data   = win_q;
    assign o_hdr_len    = len_q;
    assign o_err_cnt    = err_q;

endmodule
